// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: datapath width, ALU opcodes
// and the arbiter FSM state encoding.
// Imported by alu_arbiter and available to any block that issues ALU ops.
package alu_pkg;

  localparam int WIDTH = 16;

  // ALU opcodes. The arbiter does not decode these; it passes them to the ALU.
  localparam logic [2:0] ALU_ADD   = 3'b000;  // a + b
  localparam logic [2:0] ALU_SUB   = 3'b001;  // a - b
  localparam logic [2:0] ALU_SHL   = 3'b010;  // a << b
  localparam logic [2:0] ALU_SHR   = 3'b011;  // a >> b (logical)
  localparam logic [2:0] ALU_SAR   = 3'b100;  // a >>> b (arithmetic)
  localparam logic [2:0] ALU_NAND  = 3'b101;  // ~(a & b)
  localparam logic [2:0] ALU_OR    = 3'b110;  // a | b
  localparam logic [2:0] ALU_SHADD = 3'b111;  // a + (b << 1)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a request; the granted client sees ready
    ST_EXEC = 2'd1,  // operand registers drive the ALU
    ST_RESP = 2'd2   // result held until the owner consumes it
  } arb_state_e;

endpackage : alu_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational (zero latency).
// No backpressure of its own: the parent qualifies the grants with its state.
// Ports: valid0/valid1 requests in, last_grant (client granted most recently),
//        gnt0/gnt1 one-hot-or-zero grant out.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  // A lone requester always wins; on a tie the client that was not served
  // last goes first, which bounds any waiting client to one transaction.
  always_comb begin
    gnt0 = valid0 & (~valid1 | last_grant);
    gnt1 = valid1 & (~valid0 | ~last_grant);
  end

endmodule : rr_arb2

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two clients.
// Latency: request accepted at edge T, result valid from cycle T+2 (3-cycle turnaround).
// Backpressure: result held stable while resp_ready is low; no request is accepted until it is consumed.
// Ports: reqN_* request channels (valid/ready, a, b, op); respN_valid/respN_ready
//        response channels sharing resp_out/resp_zerof; alu_* drive/receive the external ALU.
module alu_arbiter #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  // client 0 request
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  // client 1 request
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  // responses
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_zerof,
  // ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zerof
);

  import alu_pkg::*;

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       op_op_q, op_op_d;
  logic [WIDTH-1:0] resp_out_q, resp_out_d;
  logic             resp_zerof_q, resp_zerof_d;

  logic gnt0, gnt1;
  logic acc0, acc1;
  logic resp_hs;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  // ---------------------------------------------------------------------------
  // FSM output logic. Everything is forced low while rst is asserted so that a
  // request presented in the reset cycle is never accepted and an abandoned
  // result is never offered.
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        req0_ready = gnt0;
        req1_ready = gnt1;
      end
      if (state_q == ST_RESP) begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
      end
    end
  end

  assign acc0    = req0_valid & req0_ready;
  assign acc1    = req1_valid & req1_ready;
  // Only the owner's channel can be valid, so a non-owner ready has no effect.
  assign resp_hs = (resp0_valid & resp0_ready) | (resp1_valid & resp1_ready);

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc0 || acc1) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (resp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Operand / result datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_op_d      = op_op_q;
    resp_out_d   = resp_out_q;
    resp_zerof_d = resp_zerof_q;

    if (acc0) begin
      op_a_d       = req0_a;
      op_b_d       = req0_b;
      op_op_d      = req0_op;
      owner_d      = 1'b0;
      last_grant_d = 1'b0;
    end else if (acc1) begin
      op_a_d       = req1_a;
      op_b_d       = req1_b;
      op_op_d      = req1_op;
      owner_d      = 1'b1;
      last_grant_d = 1'b1;
    end

    // The ALU has had the whole EXEC cycle to settle on the registered operands.
    if (state_q == ST_EXEC) begin
      resp_out_d   = alu_out;
      resp_zerof_d = alu_zerof;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;  // client 0 wins the first tie
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_op_q      <= '0;
      resp_out_q   <= '0;
      resp_zerof_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_op_q      <= op_op_d;
      resp_out_q   <= resp_out_d;
      resp_zerof_q <= resp_zerof_d;
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_op     = op_op_q;
  assign resp_out   = resp_out_q;
  assign resp_zerof = resp_zerof_q;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter wrapped together with a behavioural 16-bit ALU.
// Directed scenarios for the documented cases, then a randomized phase
// checked against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         resp0_valid, resp1_valid;
  logic         resp0_ready, resp1_ready;
  logic [W-1:0] resp_out;
  logic         resp_zerof;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_op;
  logic         alu_zerof;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural ALU, also used as the reference for expected results.
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a << b[3:0];
      3'b011:  return a >> b[3:0];
      3'b100:  return W'($signed(a) >>> b[3:0]);
      3'b101:  return ~(a & b);
      3'b110:  return a | b;
      default: return a + (b << 1);
    endcase
  endfunction

  assign alu_out   = alu_f(alu_a, alu_b, alu_op);
  assign alu_zerof = (alu_out == '0);

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_out(resp_out), .resp_zerof(resp_zerof),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zerof(alu_zerof)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int c);
    return (c == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rvld(input int c);
    return (c == 0) ? resp0_valid : resp1_valid;
  endfunction

  task automatic set_req(input int c, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op);
    if (c == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic set_rr(input int c, input logic v);
    if (c == 0) resp0_ready = v;
    else        resp1_ready = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // One full transaction for client c with resp_ready raised as soon as the
  // result appears; checks acceptance, EXEC operands, result timing and data.
  task automatic serve(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic [W-1:0] eo, input logic ez,
                       input string tag);
    set_req(c, 1'b1, a, b, op);
    #1;
    chk({tag, "_rdy"}, rdy(c), 1);
    chk({tag, "_rdy_other"}, rdy(1 - c), 0);
    cyc();
    set_req(c, 1'b0, a, b, op);
    #1;
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_b"}, alu_b, b);
    chk({tag, "_alu_op"}, alu_op, op);
    chk({tag, "_exec_vld"}, rvld(c), 0);
    cyc();
    chk({tag, "_resp_vld"}, rvld(c), 1);
    chk({tag, "_resp_vld_other"}, rvld(1 - c), 0);
    chk({tag, "_resp_out"}, resp_out, eo);
    chk({tag, "_resp_zerof"}, resp_zerof, ez);
    set_rr(c, 1'b1);
    cyc();
    set_rr(c, 1'b0);
    #1;
    chk({tag, "_resp_done"}, rvld(c), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          gq[$];
    int          gc[$];
    logic [W:0]  eq[$];
    int          eown[$];
    int          cnum;
    // reference model state
    int          busy, age, own, last;
    logic [W-1:0] e_out;
    logic        e_z;
    logic        er0, er1, erv0, erv1, acc0, acc1;

    // ---------------- reset state + single request ----------------
    do_reset();
    #1;
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_vld0", resp0_valid, 0);
    chk("rst_vld1", resp1_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_resp_out", resp_out, 0);
    chk("rst_zerof", resp_zerof, 0);
    serve(0, 16'h0003, 16'h0005, 3'b000, 16'h0008, 1'b0, "single");

    // ---------------- zero flag ----------------
    serve(1, 16'h1234, 16'h1234, 3'b001, 16'h0000, 1'b1, "zero");

    // ---------------- tie after reset ----------------
    do_reset();
    set_req(0, 1'b1, 16'h00F0, 16'h000F, 3'b110);
    set_req(1, 1'b1, 16'h8000, 16'h0004, 3'b100);
    serve(0, 16'h00F0, 16'h000F, 3'b110, 16'h00FF, 1'b0, "tie_c0");
    serve(1, 16'h8000, 16'h0004, 3'b100, 16'hF800, 1'b0, "tie_c1");
    set_req(0, 1'b1, 16'h0001, 16'h0001, 3'b000);
    set_req(1, 1'b1, 16'h0002, 16'h0002, 3'b000);
    #1;
    chk("tie_rearm_rdy0", req0_ready, 1);
    chk("tie_rearm_rdy1", req1_ready, 0);

    // ---------------- backpressure ----------------
    do_reset();
    set_req(0, 1'b1, 16'h1111, 16'h0000, 3'b110);
    cyc();
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 16'h0005, 16'h0006, 3'b000);
    resp1_ready = 1'b1;  // non-owner ready must be ignored
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld0", resp0_valid, 1);
      chk("bp_vld1", resp1_valid, 0);
      chk("bp_out", resp_out, 16'h1111);
      chk("bp_rdy0", req0_ready, 0);
      chk("bp_rdy1", req1_ready, 0);
      cyc();
    end
    resp0_ready = 1'b1;
    #1;
    chk("bp_hs_vld0", resp0_valid, 1);
    cyc();
    resp0_ready = 1'b0;
    #1;
    chk("bp_after_vld0", resp0_valid, 0);
    chk("bp_after_rdy1", req1_ready, 1);

    // ---------------- reset mid-flight ----------------
    do_reset();
    set_req(0, 1'b1, 16'h0042, 16'h0001, 3'b000);
    cyc();
    set_req(0, 1'b0, '0, '0, '0);
    rst = 1'b1;  // now in EXEC
    set_req(1, 1'b1, 16'h0007, 16'h0001, 3'b001);
    #1;
    chk("mid_rst_rdy1", req1_ready, 0);
    chk("mid_rst_vld0", resp0_valid, 0);
    cyc();
    rst = 1'b0;
    set_req(1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mid_rst_no_resp0", resp0_valid, 0);
      chk("mid_rst_no_resp1", resp1_valid, 0);
      cyc();
    end
    set_req(0, 1'b1, 16'h0001, 16'h0002, 3'b000);
    set_req(1, 1'b1, 16'h0003, 16'h0004, 3'b000);
    #1;
    chk("mid_rst_tie_rdy0", req0_ready, 1);
    chk("mid_rst_tie_rdy1", req1_ready, 0);

    // ---------------- throughput ----------------
    do_reset();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(0, 1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
    set_req(1, 1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
    for (int t = 0; t < 60; t++) begin
      #1;
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (acc0) begin
        gq.push_back(0); gc.push_back(t);
        e_out = alu_f(req0_a, req0_b, req0_op);
        eq.push_back({(e_out == '0), e_out}); eown.push_back(0);
      end
      if (acc1) begin
        gq.push_back(1); gc.push_back(t);
        e_out = alu_f(req1_a, req1_b, req1_op);
        eq.push_back({(e_out == '0), e_out}); eown.push_back(1);
      end
      if (resp0_valid || resp1_valid) begin
        if (eq.size() == 0) begin
          chk("tp_unexpected_resp", 0, 1);
        end else begin
          chk("tp_resp_owner", {31'd0, resp1_valid}, eown[0]);
          chk("tp_resp_data", {resp_zerof, resp_out}, eq[0]);
          void'(eq.pop_front());
          void'(eown.pop_front());
        end
      end
      cyc();
      if (acc0) set_req(0, 1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      if (acc1) set_req(1, 1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
    end
    chk("tp_count", gq.size(), 20);
    for (int i = 0; i < gq.size(); i++) begin
      chk("tp_alternate", gq[i], i % 2);
      if (i > 0) chk("tp_spacing", gc[i] - gc[i-1], 3);
    end

    // ---------------- randomized phase vs reference model ----------------
    do_reset();
    busy = 0; age = 0; own = 0; last = 1;
    e_out = '0; e_z = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0;
    cnum = 0;
    for (int t = 0; t < 3000; t++) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      rst = ($urandom_range(0, 99) == 0);
      resp0_ready = 1'($urandom_range(0, 1));
      resp1_ready = 1'($urandom_range(0, 1));
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_a = W'($urandom);
        req0_b = ($urandom_range(0, 7) == 0) ? req0_a : W'($urandom);
        req0_op = 3'($urandom_range(0, 7));
        req0_valid = 1'b1;
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_a = W'($urandom);
        req1_b = ($urandom_range(0, 7) == 0) ? req1_a : W'($urandom);
        req1_op = 3'($urandom_range(0, 7));
        req1_valid = 1'b1;
      end
      #1;
      if (rst) begin
        er0 = 1'b0; er1 = 1'b0; erv0 = 1'b0; erv1 = 1'b0;
      end else begin
        er0  = (busy == 0) && req0_valid && (!req1_valid || last == 1);
        er1  = (busy == 0) && req1_valid && (!req0_valid || last == 0);
        erv0 = (busy != 0) && (age >= 2) && (own == 0);
        erv1 = (busy != 0) && (age >= 2) && (own == 1);
      end
      chk("rnd_rdy0", req0_ready, er0);
      chk("rnd_rdy1", req1_ready, er1);
      chk("rnd_vld0", resp0_valid, erv0);
      chk("rnd_vld1", resp1_valid, erv1);
      if (erv0 || erv1) begin
        chk("rnd_out", resp_out, e_out);
        chk("rnd_zerof", resp_zerof, e_z);
      end
      acc0 = er0;
      acc1 = er1;
      if (rst) begin
        busy = 0; last = 1;
      end else if (er0) begin
        busy = 1; age = 1; own = 0; last = 0;
        e_out = alu_f(req0_a, req0_b, req0_op); e_z = (e_out == '0);
      end else if (er1) begin
        busy = 1; age = 1; own = 1; last = 1;
        e_out = alu_f(req1_a, req1_b, req1_op); e_z = (e_out == '0);
      end else if (busy != 0) begin
        if (age >= 2 && ((own == 0) ? resp0_ready : resp1_ready)) begin
          busy = 0;
          cnum++;
        end else begin
          age++;
        end
      end
      cyc();
    end
    rst = 1'b0;
    chk("rnd_progress", (cnum > 100) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_arbiter
